// File: rtl/adder_result_fifo.sv
// First-word-fall-through result FIFO between the handshake adder and its sink.
// Optional statistics outputs (push total, high-water mark) under ADDER_RESULT_FIFO_STATS_EN.
module adder_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
`ifdef ADDER_RESULT_FIFO_STATS_EN
  ,
  output logic [15:0]      total_cnt,
  output logic [CNT_W-1:0] max_level
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count_next;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  // Ready is independent of out_ready so a full FIFO never accepts a push, even alongside a pop.
  assign in_ready  = !full && !rst;
  assign out_valid = !empty;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
    end
  end

  // Storage is intentionally left out of reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

`ifdef ADDER_RESULT_FIFO_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_cnt <= '0;
      max_level <= '0;
    end else begin
      if (push && (total_cnt != 16'hFFFF)) total_cnt <= total_cnt + 16'd1;
      if (count_next > max_level) max_level <= count_next;
    end
  end
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && push && full)  $error("adder_result_fifo: push while full");
    if (!rst && pop && empty)  $error("adder_result_fifo: pop while empty");
  end
`endif

endmodule

// File: tb/tb_adder_result_fifo.sv
// Scoreboard bench for adder_result_fifo: stimulus pushes expected sums, a negedge monitor pops and compares.
module tb_adder_result_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
`ifdef ADDER_RESULT_FIFO_STATS_EN
  logic [15:0]      total_cnt;
  logic [CNT_W-1:0] max_level;
`endif

  adder_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
`ifdef ADDER_RESULT_FIFO_STATS_EN
    ,
    .total_cnt (total_cnt),
    .max_level (max_level)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_pops = 0;
  int rst_cnt = 0;
  logic [WIDTH-1:0] cur_exp = '0;
  logic [WIDTH-1:0] q[$];

  logic             hold_v = 1'b0;
  logic [WIDTH-1:0] hold_d = '0;
  int               hold_rst = 0;

  always @(posedge rst) rst_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare head on every pop, check hold stability, record accepted pushes.
  always @(negedge clk) begin
    logic [WIDTH-1:0] exp_d;
    if (!rst) begin
      if (hold_v && hold_rst == rst_cnt) begin
        total++;
        if (!out_valid || out_data !== hold_d) begin
          bad++;
          $display("FAIL hold_stable: got valid=%0b data=%0h expected valid=1 data=%0h",
                   out_valid, out_data, hold_d);
        end
      end
      if (out_valid && out_ready) begin
        n_pops++;
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL pop_unexpected: got data=%0h expected no output", out_data);
        end else begin
          exp_d = q.pop_front();
          if (out_data !== exp_d) begin
            bad++;
            $display("FAIL pop_data: got %0h expected %0h", out_data, exp_d);
          end
        end
      end
      if (in_valid && in_ready) q.push_back(cur_exp);
      hold_v   = out_valid && !out_ready;
      hold_d   = out_data;
      hold_rst = rst_cnt;
    end
  end

  // Entered and left at posedge+1; holds in_valid until accepted, bounded.
  task automatic push_one(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp);
    int guard = 0;
    in_data  = a + b;
    cur_exp  = exp;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      guard++;
    end while (!in_ready && guard < 50);
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL push_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int p0;
    // Reset state
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 1);

    // Single transfer 0x12+0x34
    out_ready = 1'b1;
    push_one(8'h12, 8'h34, 8'h46);
    check("single_latency_valid", 32'(out_valid), 1);
    check("single_latency_data", 32'(out_data), 32'h46);
    @(posedge clk); #1;
    check("single_count", 32'(count), 0);
    check("single_empty", 32'(empty), 1);

    // Fill to full with sink stalled
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_one(8'(i), 8'h00, 8'(i));
    check("fill_full", 32'(full), 1);
    check("fill_in_ready", 32'(in_ready), 0);
    check("fill_count", 32'(count), 4);
    in_data = 8'h05; cur_exp = 8'h05; in_valid = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("overfill_count", 32'(count), 4);
    in_valid = 1'b0;

    // Drain one per cycle
    p0 = n_pops;
    out_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("drain_pops", n_pops - p0, 4);
    check("drain_empty", 32'(empty), 1);
    check("drain_out_valid", 32'(out_valid), 0);

    // Steady push+pop at count=2 across pointer wrap
    out_ready = 1'b0;
    push_one(8'h00, 8'h0E, 8'h0E);
    push_one(8'h00, 8'h0F, 8'h0F);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data  = 8'(8'h10 + i);
      cur_exp  = 8'(8'h10 + i);
      in_valid = 1'b1;
      @(negedge clk);
      check("stream_count", 32'(count), 2);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("stream_after_count", 32'(count), 2);
    repeat (2) @(posedge clk); #1;
    check("stream_empty", 32'(empty), 1);

    // Zero-valued sum from 8-bit overflow
    out_ready = 1'b0;
    push_one(8'hFF, 8'h01, 8'h00);
    check("zero_out_valid", 32'(out_valid), 1);
    check("zero_out_data", 32'(out_data), 0);
    check("zero_count", 32'(count), 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("zero_empty", 32'(empty), 1);

    // Asynchronous reset with three entries buffered
    out_ready = 1'b0;
    push_one(8'h20, 8'h01, 8'h21);
    push_one(8'h20, 8'h02, 8'h22);
    push_one(8'h20, 8'h03, 8'h23);
    check("pre_rst_count", 32'(count), 3);
    check("pre_rst_out_valid", 32'(out_valid), 1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_out_data", 32'(out_data), 0);
    check("mid_rst_in_ready", 32'(in_ready), 0);
    q.delete();
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    push_one(8'h2D, 8'h2D, 8'h5A);
    check("post_rst_out_valid", 32'(out_valid), 1);
    check("post_rst_out_data", 32'(out_data), 32'h5A);
`ifdef ADDER_RESULT_FIFO_STATS_EN
    check("stats_total_cnt", 32'(total_cnt), 1);
    check("stats_max_level", 32'(max_level), 1);
`endif
    @(posedge clk); #1;
    check("post_rst_empty", 32'(empty), 1);
    check("scoreboard_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adder_result_fifo.md
Name: adder_result_fifo

Overview:
- Downstream stage of the 8-bit handshake adder.
- Accepts each sum via the adder's valid/ready output handshake and buffers it in a small first-word-fall-through FIFO.
- Presents results to the sink (scoreboard port or next datapath stage) through its own valid/ready handshake.
- Decouples adder throughput from sink backpressure.

Parameters:
- WIDTH, 8, data width; must equal the adder's WIDTH.
- DEPTH, 4, number of FIFO entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  rising-edge clock, shared with the adder.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  driven by the adder's out_valid.
- in_ready  output  1  drives the adder's out_ready.
- in_data  input  WIDTH  driven by the adder's sum.
- out_valid  output  1  head entry available to the sink.
- out_ready  input  1  sink accepts the head entry.
- out_data  output  WIDTH  head entry value.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset state: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, out_valid=0, out_data=0. Memory contents are not reset.
- in_ready: in_ready = !full, and is forced 0 while rst is high.
  - in_ready does not depend on out_ready: a pop in the same cycle does not allow a push into a full FIFO.
- push = in_valid && in_ready. On push, mem[wr_ptr] <= in_data and wr_ptr advances.
- pop = out_valid && out_ready. On pop, rd_ptr advances.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged.
- Output side:
  - out_valid = !empty.
  - out_data = mem[rd_ptr] when out_valid is 1, otherwise 0.
  - This is first-word-fall-through: the head is visible with no extra read cycle.
- Latency: a sum pushed at clock edge N appears on out_data with out_valid=1 in the cycle after edge N, when the FIFO was empty before the push.
- Empty: pop is impossible because out_valid=0. out_ready is ignored.
- Full: in_ready=0. An upstream in_valid is held off; the adder remains in its WAIT state and holds sum stable.
- Data integrity: in_data is sampled only on a push edge. Values are delivered in push order with no loss or duplication.
- Reset mid-operation: all buffered entries are discarded and the reset state applies immediately (asynchronous). Both handshakes drop: in_ready=0, out_valid=0. After rst deasserts, the first clock edge may accept a push.
- Handshake legality: out_valid never deasserts without a pop, and out_data is stable while out_valid=1 && out_ready=0, except during reset.
- Assertion (simulation only): push when full, or pop when empty, flags $error.

Optional Feature:
- Macro: ADDER_RESULT_FIFO_STATS_EN.
- When defined, two extra outputs are added:
  - total_cnt (16 bits): number of pushes since reset, saturating at 16'hFFFF.
  - max_level (CNT_W bits): high-water mark of count since reset.
  - Both reset to 0 and update on the same edge as the push or count change.
- When undefined, these ports and their registers do not exist and the behaviour is otherwise identical.

Test Plan:
- Single transfer: reset, then push a=0x12+b=0x34 (in_data=0x46) with out_ready=1. out_valid=1 the next cycle with out_data=0x46, pop occurs, count returns to 0 and empty=1.
- Fill to full: DEPTH=4, out_ready=0, push 0x01,0x02,0x03,0x04. After the 4th push full=1 and in_ready=0. A 5th in_valid with 0x05 is not accepted and count stays 4.
- Drain order: from full, set out_ready=1. out_data sequence is 0x01,0x02,0x03,0x04, one per cycle, then out_valid=0 and empty=1.
- Simultaneous push/pop and wrap: keep count=2 while pushing and popping every cycle for 10 cycles with values 0x10..0x19. Outputs appear in order, count stays 2, and pointers wrap with no corruption.
- Overflow arithmetic pass-through: in_data=0xFF+0x01 truncated result 0x00 is pushed and stored as 0x00. out_valid=1 with out_data=0x00, distinguishing an empty FIFO (out_valid=0) from a zero value.
- Reset mid-operation: with count=3 and out_valid=1, pulse rst for one cycle between edges. Immediately count=0, out_valid=0, out_data=0 and in_ready=0. After release, a push of 0x5A is the first value out. With ADDER_RESULT_FIFO_STATS_EN defined, total_cnt=1 after that push.
